// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the multi-port register file.
package regfile_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 16;

    // Address width that stays at least one bit even for a 2-entry file.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    localparam int DEF_ADDR_W = addr_width(DEF_DEPTH);

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: claims set, writes clear, claim beats write.
// Exposes the same-cycle clear mask so the read ports can bypass busy-clear.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = addr_width(DEPTH),
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    output logic [DEPTH-1:0]         busy,
    output logic [DEPTH-1:0]         clr_mask,
    output logic [ADDR_W:0]          busy_cnt
);

    logic [DEPTH-1:0] wr_mask;
    logic [DEPTH-1:0] set_mask;
    logic [DEPTH-1:0] busy_next;
    logic [ADDR_W:0]  cnt_next;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        wr_mask  = '0;
        set_mask = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) wr_mask[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b1;
        end
        if (claim_en) set_mask[claim_addr] = 1'b1;
        if (ZERO_REG != 0) begin
            wr_mask[0]  = 1'b0;
            set_mask[0] = 1'b0;
        end
        // A new producer supersedes the retiring one on the same register.
        clr_mask  = wr_mask & ~set_mask;
        busy_next = (busy & ~clr_mask) | set_mask;
        cnt_next  = '0;
        for (int r = 0; r < DEPTH; r++) begin
            cnt_next = cnt_next + (ADDR_W+1)'(busy_next[r]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Parametrised multi-port register file with optional zero register,
// write-to-read bypass and a busy scoreboard for RAW hazard detection.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = addr_width(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    output logic [ADDR_W:0]          busy_cnt
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  clr_mask;

    // NOTE: the storage array is reset here because the core relies on all registers reading 0 after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
        end else begin
            // Later ports overwrite earlier ones, so the highest index wins.
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && !(ZERO_REG != 0 && wr_addr[w*ADDR_W +: ADDR_W] == '0))
                    mem[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
            end
        end
    end

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .busy       (busy),
        .clr_mask   (clr_mask),
        .busy_cnt   (busy_cnt)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] data;
        logic              busy_q;

        assign ra = rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            data   = mem[ra];
            busy_q = busy[ra];
            if (BYPASS != 0) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] == ra)
                        data = wr_data[w*DATA_W +: DATA_W];
                end
                busy_q = busy[ra] & ~clr_mask[ra];
            end
            // Reset masks in-flight bypass data as well as the cleared storage.
            if (reset || (ZERO_REG != 0 && ra == '0)) begin
                data   = '0;
                busy_q = 1'b0;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = data;
        assign rd_busy[i]                  = busy_q;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-port register file for the pipelined 16-bit core. It is the successor to the single-write, dual-read register file and adds:
- configurable width, depth and read/write port counts;
- an optional hardwired zero register;
- optional write-to-read bypass;
- a per-register busy scoreboard that the issue stage uses to detect RAW hazards on in-flight results.

Parameters:
DATA_W, 16, data width of each register
DEPTH, 16, number of registers (power of two, >= 2)
ADDR_W, $clog2(DEPTH), address width (derived, do not override)
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 2, number of write ports (1..2)
ZERO_REG, 0, 1 = register 0 reads as zero, ignores writes and claims
BYPASS, 1, 1 = same-cycle write data and busy-clear visible on read ports

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all registers and busy bits
rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data, combinational
rd_busy  out  NUM_RD  busy bit of the addressed register, combinational
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*ADDR_W  packed write addresses
wr_data  in  NUM_WR*DATA_W  packed write data
claim_en  in  1  issue stage reserves a destination register
claim_addr  in  ADDR_W  register to mark busy
busy_cnt  out  ADDR_W+1  registered count of busy registers

Behaviour:
- Reset (async, active-high):
  - all DEPTH registers <= 0, all busy bits <= 0, busy_cnt <= 0;
  - while reset is asserted, rd_data = 0 and rd_busy = 0 for every port (inputs ignored);
  - reset mid-operation discards pending claims; the first write after release behaves as if into an idle file.
- Writes (registered on posedge clk, when not in reset):
  - for each port w with wr_en[w], mem[wr_addr[w]] <= wr_data[w];
  - both ports on the same address in the same cycle: port NUM_WR-1 (highest index) wins.
- Reads: combinational.
  - BYPASS=0: rd_data[i] = mem[rd_addr[i]].
  - BYPASS=1: if any enabled write port targets rd_addr[i] this cycle, rd_data[i] = that port's wr_data (highest index wins); otherwise mem.
  - Read latency 0 cycles; write-to-read latency 0 with BYPASS=1, 1 cycle with BYPASS=0.
- ZERO_REG=1, address 0:
  - reads return 0 and bypass is suppressed;
  - writes and claims are dropped;
  - busy[0] is constantly 0.
- Scoreboard (busy[DEPTH-1:0], registered):
  - set: claim_en, busy[claim_addr] <= 1;
  - clear: any wr_en[w] with wr_addr[w]==r, busy[r] <= 0;
  - claim and write on the same address in the same cycle: claim wins, busy stays/becomes 1 (a new producer supersedes the retiring one);
  - claim to an already-busy register: it stays 1, with no error or count change.
- rd_busy[i]:
  - BYPASS=0: busy[rd_addr[i]];
  - BYPASS=1: 0 if a same-cycle write to rd_addr[i] clears it and there is no simultaneous claim of that address; otherwise busy[rd_addr[i]].
- busy_cnt:
  - registered popcount of the next-state busy vector, so it equals popcount(busy) every cycle;
  - range 0..DEPTH, or 0..DEPTH-1 when ZERO_REG=1;
  - width ADDR_W+1, so DEPTH never wraps.
- Addresses are always in range (DEPTH is a power of two), so there is no out-of-range case.

Decomposition:
- Package regfile_pkg:
  - default DATA_W/DEPTH constants;
  - function clog2-safe address width;
  - typedef reg_addr_t, reg_data_t for the 16x16 core configuration.
- One sub-module, rf_scoreboard: holds busy bits, claim/clear priority and busy_cnt; exports the busy vector and the next-state clear mask for bypass.
- Data storage, write arbitration and read/bypass muxing stay in the top.

Test Plan:
- Reset: write 0xBEEF to r3, then assert reset asynchronously mid-cycle -> rd_data for r3 = 0 immediately, busy_cnt = 0 after release.
- Write/read ports: write r5=0x1234 on port 0 and r9=0xABCD on port 1 in the same cycle, then read r5/r9 on ports 0/1 -> 0x1234 / 0xABCD next cycle (BYPASS=0).
- Conflict and bypass: both ports write r7 (0x1111 on port 0, 0x2222 on port 1) while reading r7 with BYPASS=1 -> rd_data = 0x2222 the same cycle and mem[r7] = 0x2222 afterwards.
- Zero register (ZERO_REG=1): write r0=0xFFFF and claim r0 -> reads return 0x0000, rd_busy = 0, busy_cnt unchanged.
- Scoreboard: claim r4, r6, r8 on consecutive cycles -> busy_cnt = 3. Then write r6 -> rd_busy(r6) = 0 the same cycle (BYPASS=1) and busy_cnt = 2 the next cycle.
- Claim/write collision and full scoreboard: claim r2 while writing r2 in the same cycle -> busy[r2] = 1. Then claim all 16 registers (ZERO_REG=0) -> busy_cnt = 16 with no wrap.
